// File: rtl/control_pkg.sv
// control_pkg: opcodes, FSM states, instruction classes and datapath mux encodings
package control_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] ALU_IMM_I = 2'b00;
  localparam logic [1:0] ALU_IMM_S = 2'b01;
  localparam logic [1:0] ALU_RS2   = 2'b10;
  localparam logic [1:0] ALU_PC    = 2'b11;
  localparam logic [2:0] WB_IMM_U = 3'b000;
  localparam logic [2:0] WB_ALU   = 3'b001;
  localparam logic [2:0] WB_MEM   = 3'b010;
  localparam logic [2:0] WB_NONE  = 3'b011;
  localparam logic [2:0] WB_PC4   = 3'b100;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    TRAP      = 3'd6
  } state_e;
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
  } instr_class_t;
endpackage

// File: rtl/instr_class_decoder.sv
// instr_class_decoder: maps opcode/funct3/funct7 to a one-hot instruction class and an illegal flag
module instr_class_decoder
  import control_pkg::*;
#(
  parameter bit ENABLE_JUMPS = 1'b1
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  output instr_class_t cls,
  output logic         illegal
);
  logic bad_funct;
  always_comb begin
    cls.lui    = opcode == OPC_LUI;
    cls.auipc  = opcode == OPC_AUIPC;
    cls.jal    = ENABLE_JUMPS && opcode == OPC_JAL;
    cls.jalr   = ENABLE_JUMPS && opcode == OPC_JALR;
    cls.branch = ENABLE_JUMPS && opcode == OPC_BRANCH;
    cls.load   = opcode == OPC_LOAD;
    cls.store  = opcode == OPC_STORE;
    cls.op_imm = opcode == OPC_OP_IMM;
    cls.op     = opcode == OPC_OP;
    bad_funct = (cls.load && funct3 inside {3'b011, 3'b110, 3'b111})
             || (cls.store && funct3 > 3'b010)
             || (cls.branch && funct3 inside {3'b010, 3'b011})
             || (cls.jalr && funct3 != 3'b000)
             || (cls.op && !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 inside {3'b000, 3'b101})))
             || (cls.op_imm && funct3 == 3'b001 && funct7 != 7'b0000000)
             || (cls.op_imm && funct3 == 3'b101 && !(funct7 inside {7'b0000000, 7'b0100000}));
    // every supported opcode ends in 2'b11, so a zero class also covers bad low bits
    illegal = cls == '0 || bad_funct;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I sequencer driving PC, IR, regfile, ALU muxes and the memory port
module multicycle_control_fsm
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT_CYCLES = 16,
  parameter int RESET_STALL        = 2,
  parameter bit ENABLE_JUMPS       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] instr_i,
  input  logic        branch_taken_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_is_fetch_o,
  output logic        mem_write_enable_o,
  output logic        ir_write_enable_o,
  output logic        pc_write_enable_o,
  output logic [1:0]  pc_src_o,
  output logic        reg_write_enable_o,
  output logic [1:0]  alu_src_o,
  output logic [2:0]  reg_write_src_o,
  output logic        illegal_instr_o,
  output logic        timeout_o,
  output logic [2:0]  state_o
);
  localparam int TW = $clog2(MEM_TIMEOUT_CYCLES + 2);
  localparam int SW = $clog2(RESET_STALL + 1);
  state_e state, next;
  instr_class_t cls_d, cls_q;
  logic illegal_d, illegal_q, timeout_q;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] stall_cnt;
  logic mem_state, wait_hit, jump, link, unused_bits;
  logic [1:0] cls_alu_src;
  instr_class_decoder #(.ENABLE_JUMPS(ENABLE_JUMPS)) u_dec (
    .opcode (instr_i[6:0]),
    .funct3 (instr_i[14:12]),
    .funct7 (instr_i[31:25]),
    .cls    (cls_d),
    .illegal(illegal_d)
  );
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};
  assign mem_state = state == FETCH || state == MEMORY;
  // the last permitted wait cycle traps unless ready arrives in it
  assign wait_hit = MEM_TIMEOUT_CYCLES != 0 && mem_state && !mem_ready_i
                 && wait_cnt == TW'(MEM_TIMEOUT_CYCLES - 1);
  assign jump = cls_q.branch || cls_q.jal || cls_q.jalr;
  assign link = cls_q.jal || cls_q.jalr;
  assign cls_alu_src = cls_q.store ? ALU_IMM_S : cls_q.op ? ALU_RS2
                     : (cls_q.load || cls_q.op_imm || cls_q.jalr) ? ALU_IMM_I : ALU_PC;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state     <= IDLE;
      cls_q     <= '0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= next;
      if (state == DECODE) cls_q <= cls_d;
      stall_cnt <= state == IDLE ? stall_cnt + 1'b1 : '0;
      wait_cnt  <= next != state ? '0 : (mem_state && !mem_ready_i) ? wait_cnt + 1'b1 : wait_cnt;
      if (state == DECODE && illegal_d) illegal_q <= 1'b1;
      if (wait_hit) timeout_q <= 1'b1;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = stall_cnt == SW'(RESET_STALL - 1) ? FETCH : IDLE;
      FETCH:     next = mem_ready_i ? DECODE : wait_hit ? TRAP : FETCH;
      DECODE:    next = illegal_d ? TRAP : EXECUTE;
      EXECUTE:   next = jump ? FETCH : (cls_q.load || cls_q.store) ? MEMORY : WRITEBACK;
      MEMORY:    next = mem_ready_i ? (cls_q.store ? FETCH : WRITEBACK) : wait_hit ? TRAP : MEMORY;
      WRITEBACK: next = FETCH;
      default:   next = TRAP;
    endcase
  end
  always_comb begin
    mem_req_o          = mem_state;
    mem_is_fetch_o     = state == FETCH;
    mem_write_enable_o = state == MEMORY && cls_q.store;
    ir_write_enable_o  = state == FETCH && mem_ready_i;
    pc_write_enable_o  = (state == EXECUTE && jump) || (state == MEMORY && mem_ready_i && cls_q.store)
                      || state == WRITEBACK;
    pc_src_o           = state != EXECUTE ? PC_PLUS4 : cls_q.jalr ? PC_ALU
                       : (cls_q.jal || (cls_q.branch && branch_taken_i)) ? PC_IMM : PC_PLUS4;
    reg_write_enable_o = (state == EXECUTE && link) || state == WRITEBACK;
    reg_write_src_o    = (state == EXECUTE && link) ? WB_PC4 : state != WRITEBACK ? WB_NONE
                       : cls_q.lui ? WB_IMM_U : cls_q.load ? WB_MEM : WB_ALU;
    alu_src_o          = state inside {EXECUTE, MEMORY, WRITEBACK} ? cls_alu_src : ALU_PC;
    illegal_instr_o    = illegal_q;
    timeout_o          = timeout_q;
    state_o            = state;
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed checks of the multi-cycle control FSM
module tb_multicycle_control_fsm;
  logic clk = 1'b0, rst_n = 1'b1, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = 32'h00000013;
  logic mem_req, mem_is_fetch, mem_we, ir_we, pc_we, rwe, illegal, timeout;
  logic [1:0] pc_src, alu_src;
  logic [2:0] rws, state;
  logic mem_req_nj, mem_is_fetch_nj, mem_we_nj, ir_we_nj, pc_we_nj, rwe_nj, illegal_nj, timeout_nj;
  logic [1:0] pc_src_nj, alu_src_nj;
  logic [2:0] rws_nj, state_nj;
  logic [17:0] obs, obs_nj, exp;
  int total = 0, bad = 0;
  multicycle_control_fsm dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_is_fetch_o(mem_is_fetch), .mem_write_enable_o(mem_we), .ir_write_enable_o(ir_we),
    .pc_write_enable_o(pc_we), .pc_src_o(pc_src), .reg_write_enable_o(rwe), .alu_src_o(alu_src),
    .reg_write_src_o(rws), .illegal_instr_o(illegal), .timeout_o(timeout), .state_o(state)
  );
  multicycle_control_fsm #(.ENABLE_JUMPS(1'b0)) dut_nj (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req_nj), .mem_is_fetch_o(mem_is_fetch_nj), .mem_write_enable_o(mem_we_nj),
    .ir_write_enable_o(ir_we_nj), .pc_write_enable_o(pc_we_nj), .pc_src_o(pc_src_nj),
    .reg_write_enable_o(rwe_nj), .alu_src_o(alu_src_nj), .reg_write_src_o(rws_nj),
    .illegal_instr_o(illegal_nj), .timeout_o(timeout_nj), .state_o(state_nj)
  );
  // {state, req, fetch, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src, wb_src, illegal, timeout}
  assign obs = {state, mem_req, mem_is_fetch, mem_we, ir_we, pc_we, pc_src, rwe, alu_src, rws, illegal, timeout};
  assign obs_nj = {state_nj, mem_req_nj, mem_is_fetch_nj, mem_we_nj, ir_we_nj, pc_we_nj, pc_src_nj,
                   rwe_nj, alu_src_nj, rws_nj, illegal_nj, timeout_nj};
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; #1;
    exp = {3'd0, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_hold got=%b exp=%b", obs, exp); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    exp = {3'd1, 5'b11000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL fetch_req got=%b exp=%b", obs, exp); end
    #2; rst_n = 1'b0; #1;
    exp = {3'd0, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL async_drop got=%b exp=%b", obs, exp); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL stall_edge1 got=%0d exp=0", state); end
    @(negedge clk); #1;
    total++; if (state !== 3'd1) begin bad++; $display("FAIL stall_edge2 got=%0d exp=1", state); end
  endtask

  task automatic test_addi();
    do_reset(); instr = 32'h00500093; mem_ready = 1'b1; #1;
    exp = {3'd1, 5'b11010, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL addi_fetch got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd2, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL addi_decode got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd3, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL addi_exec got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd5, 5'b00001, 2'b00, 1'b1, 2'b00, 3'b001, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL addi_wb got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd1, 5'b11010, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL addi_refetch got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_load();
    do_reset(); instr = 32'h0000A103; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0; #1;
    exp = {3'd3, 5'b00000, 2'b00, 1'b0, 2'b00, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL lw_exec got=%b exp=%b", obs, exp); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      exp = {3'd4, 5'b10000, 2'b00, 1'b0, 2'b00, 3'b011, 2'b00};
      total++; if (obs !== exp) begin bad++; $display("FAIL lw_mem%0d got=%b exp=%b", i, obs, exp); end
    end
    @(negedge clk); #1; exp = {3'd5, 5'b00001, 2'b00, 1'b1, 2'b00, 3'b010, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL lw_wb got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_store();
    do_reset(); instr = 32'h0020A023; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1; exp = {3'd3, 5'b00000, 2'b00, 1'b0, 2'b01, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL sw_exec got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd4, 5'b10101, 2'b00, 1'b0, 2'b01, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL sw_mem got=%b exp=%b", obs, exp); end
    @(negedge clk); #1; exp = {3'd1, 5'b11010, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL sw_refetch got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_back_to_back_branch();
    do_reset(); instr = 32'h00208463; mem_ready = 1'b1; branch_taken = 1'b1;
    @(negedge clk);
    @(negedge clk); #1; exp = {3'd3, 5'b00001, 2'b01, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL beq_taken got=%b exp=%b", obs, exp); end
    @(negedge clk); branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk); #1; exp = {3'd3, 5'b00001, 2'b00, 1'b0, 2'b11, 3'b011, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL beq_not_taken got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_jalr();
    do_reset(); instr = 32'h000080E7; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1; exp = {3'd3, 5'b00001, 2'b10, 1'b1, 2'b00, 3'b100, 2'b00};
    total++; if (obs !== exp) begin bad++; $display("FAIL jalr_exec got=%b exp=%b", obs, exp); end
    exp = {3'd6, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b10};
    total++; if (obs_nj !== exp) begin bad++; $display("FAIL jalr_nojump_trap got=%b exp=%b", obs_nj, exp); end
  endtask

  task automatic test_illegal();
    logic [31:0] vec [10] = '{32'h40208033, 32'h40209033, 32'h00003003, 32'h00003023, 32'h00002063,
                              32'h00001093, 32'h02001093, 32'h40005093, 32'h20005093, 32'h00500091};
    logic        ill [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] want;
    for (int i = 0; i < 10; i++) begin
      do_reset(); instr = vec[i]; mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); #1; want = ill[i] ? 4'b1101 : 4'b0110;
      total++;
      if ({state, illegal} !== want) begin
        bad++; $display("FAIL decode_%h got=%b exp=%b", vec[i], {state, illegal}, want);
      end
    end
    do_reset(); instr = 32'hFFFFFFFF; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1; exp = {3'd6, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b10};
    total++; if (obs !== exp) begin bad++; $display("FAIL illegal_trap got=%b exp=%b", obs, exp); end
    instr = 32'h00500093;
    repeat (3) @(negedge clk); #1;
    total++; if (obs !== exp) begin bad++; $display("FAIL illegal_sticky got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_timeout();
    do_reset(); instr = 32'h00000013;
    repeat (15) @(negedge clk); #1;
    total++; if ({state, timeout} !== 4'b0010) begin bad++; $display("FAIL timeout_last_wait got=%b exp=0010", {state, timeout}); end
    @(negedge clk); #1; exp = {3'd6, 5'b00000, 2'b00, 1'b0, 2'b11, 3'b011, 2'b01};
    total++; if (obs !== exp) begin bad++; $display("FAIL timeout_trap got=%b exp=%b", obs, exp); end
    do_reset();
    repeat (15) @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); #1;
    total++; if ({state, timeout} !== 4'b0100) begin bad++; $display("FAIL timeout_ready_wins got=%b exp=0100", {state, timeout}); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load();
    test_store();
    test_back_to_back_branch();
    test_jalr();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
